// File: rtl/overload_frame_tx.sv
// CAN overload frame transmitter: drives the overload flag and delimiter on canTX in step
// with bit timing, monitors canRX for bit errors, and reports completion to the IFS detector.
module overload_frame_tx #(
  parameter int unsigned FlagBits     = 6,
  parameter int unsigned DelimBits    = 8,
  parameter int unsigned MaxSuperpos  = 7,
  parameter int unsigned MaxOverloads = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic bitStart,
  input  logic samplePoint,
  input  logic canRX,
  input  logic frameReady,
  input  logic isOverload,
  output logic canTX,
  output logic busy,
  output logic endOverload,
  output logic overloadDenied,
  output logic txError
);

  localparam int unsigned BitW   = $clog2(FlagBits + 1);
  localparam int unsigned DomW   = $clog2(MaxSuperpos + 1);
  localparam int unsigned DelimW = $clog2(DelimBits + 1);

  localparam logic [BitW-1:0]   FlagLast  = BitW'(FlagBits);
  localparam logic [DomW-1:0]   DomLimit  = DomW'(MaxSuperpos);
  localparam logic [DelimW-1:0] DelimLast = DelimW'(DelimBits);
  localparam logic [DelimW-1:0] DelimPrev = DelimW'(DelimBits - 1);
  localparam logic [1:0]        OvlMax    = 2'(MaxOverloads);

  typedef enum logic [2:0] {
    StIdle, StArmed, StFlag, StDelimWait, StDelim, StDone
  } state_e;

  state_e              state_q, state_d;
  logic                tx_q, tx_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DomW-1:0]     dom_cnt_q, dom_cnt_d;
  logic [DelimW-1:0]   delim_cnt_q, delim_cnt_d;
  logic [1:0]          ovl_cnt_q, ovl_cnt_d;
  logic                deny_q, deny_d;
  logic                err_q, err_d;
  logic                den_q, den_d;
  logic                ovl_inc;
  logic                grant_ok;

  assign grant_ok = (ovl_cnt_q < OvlMax);

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    bit_cnt_d   = bit_cnt_q;
    dom_cnt_d   = dom_cnt_q;
    delim_cnt_d = delim_cnt_q;
    err_d       = 1'b0;
    den_d       = 1'b0;
    ovl_inc     = 1'b0;
    // A denied request stays ignored until the detector drops it.
    deny_d      = deny_q & isOverload;

    // Bit-start actions first; the sample point then sees the resulting state.
    unique case (state_q)
      StIdle: begin
        if (isOverload && !deny_q) begin
          if (grant_ok) begin
            state_d = StArmed;
            ovl_inc = 1'b1;
          end else begin
            den_d  = 1'b1;
            deny_d = 1'b1;
          end
        end
      end
      StArmed: begin
        if (bitStart) begin
          tx_d      = 1'b0;
          bit_cnt_d = BitW'(1);
          state_d   = StFlag;
        end
      end
      StFlag: begin
        if (bitStart) begin
          if (bit_cnt_q < FlagLast) begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            tx_d      = 1'b0;
          end else begin
            tx_d      = 1'b1;
            dom_cnt_d = '0;
            state_d   = StDelimWait;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: ;
    endcase

    if (samplePoint) begin
      unique case (state_d)
        StFlag: begin
          if (canRX) begin
            err_d   = 1'b1;
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end
        StDelimWait: begin
          if (canRX) begin
            delim_cnt_d = DelimW'(1);
            state_d     = StDelim;
          end else begin
            dom_cnt_d = dom_cnt_d + DomW'(1);
            if (dom_cnt_d == DomLimit) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StDelim: begin
          if (canRX) begin
            delim_cnt_d = delim_cnt_d + DelimW'(1);
            if (delim_cnt_d == DelimLast) state_d = StDone;
          end else if (delim_cnt_d == DelimPrev) begin
            // Dominant on the last delimiter bit is another overload condition.
            if (grant_ok) begin
              state_d = StArmed;
              ovl_inc = 1'b1;
            end else begin
              den_d   = 1'b1;
              state_d = StIdle;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: ;
      endcase
    end

    if (!frameReady) begin
      ovl_cnt_d = '0;
    end else if (ovl_inc && ovl_cnt_q != 2'b11) begin
      ovl_cnt_d = ovl_cnt_q + 2'd1;
    end else begin
      ovl_cnt_d = ovl_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      tx_q        <= 1'b1;
      bit_cnt_q   <= '0;
      dom_cnt_q   <= '0;
      delim_cnt_q <= '0;
      ovl_cnt_q   <= '0;
      deny_q      <= 1'b0;
      err_q       <= 1'b0;
      den_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      dom_cnt_q   <= dom_cnt_d;
      delim_cnt_q <= delim_cnt_d;
      ovl_cnt_q   <= ovl_cnt_d;
      deny_q      <= deny_d;
      err_q       <= err_d;
      den_q       <= den_d;
    end
  end

  assign canTX          = tx_q;
  assign busy           = (state_q != StIdle);
  assign endOverload    = (state_q == StDone);
  assign overloadDenied = den_q;
  assign txError        = err_q;

endmodule
